// File: rtl/spi_readout_pkg.sv
// Shared types and constants for the SPI frame readout scheduler.
package spi_readout_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      DONE
   } state_t;

   localparam logic [7:0] HDR_BYTE  = 8'hA5;
   localparam logic [7:0] FILL_BYTE = 8'h07;
   localparam logic [7:0] IDLE_BYTE = 8'h00;

   localparam int unsigned FETCH_LATENCY = 3;

   // Counter width that stays at least one bit for a range of one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_readout_sched_if.sv
// SPI byte handshake and mic FIFO read port seen by the readout scheduler.
interface spi_readout_sched_if #(
   parameter int unsigned NUM_MICS  = 9,
   parameter int unsigned BIT_WIDTH = 8
);
   logic                          frame_start;
   logic                          byte_req;
   logic [NUM_MICS-1:0]           fifo_rdempty;
   logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q;
   logic [NUM_MICS-1:0]           fifo_rdreq;
   logic [7:0]                    tx_data;
   logic                          tx_valid;

   modport master (
      input  frame_start, byte_req, fifo_rdempty, fifo_q,
      output fifo_rdreq, tx_data, tx_valid
   );

   modport slave (
      output frame_start, byte_req, fifo_rdempty, fifo_q,
      input  fifo_rdreq, tx_data, tx_valid
   );
endinterface

// File: rtl/spi_readout_sched_cursor.sv
// Mic/sample position within a frame, mic-minor, sample-major.
module readout_cursor
   import spi_readout_pkg::*;
#(
   parameter int unsigned NUM_MICS          = 9,
   parameter int unsigned SAMPLES_PER_FRAME = 4,
   localparam int unsigned MIC_W    = cnt_width(NUM_MICS),
   localparam int unsigned SAMPLE_W = cnt_width(SAMPLES_PER_FRAME)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                advance,
   output logic [MIC_W-1:0]    mic,
   output logic [SAMPLE_W-1:0] sample,
   output logic                last
);

   logic mic_wrap;
   logic sample_wrap;

   assign mic_wrap    = (mic == MIC_W'(NUM_MICS - 1));
   assign sample_wrap = (sample == SAMPLE_W'(SAMPLES_PER_FRAME - 1));
   assign last        = mic_wrap && sample_wrap;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         mic    <= '0;
         sample <= '0;
      end else if (advance) begin
         if (mic_wrap) begin
            mic    <= '0;
            sample <= sample_wrap ? '0 : sample + SAMPLE_W'(1);
         end else begin
            mic <= mic + MIC_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_readout_sched.sv
// Frame scheduler: header bytes, then mic FIFO words one per SPI byte request,
// with a fixed three-cycle request-to-byte pipeline.
module spi_readout_sched
   import spi_readout_pkg::*;
#(
   parameter int unsigned NUM_MICS          = 9,
   parameter int unsigned BIT_WIDTH         = 8,
   parameter int unsigned SAMPLES_PER_FRAME = 4
) (
   input  logic                clk,
   input  logic                rst,
   spi_readout_sched_if.master bus,
   output logic                busy,
   output logic [7:0]          frame_count,
   output logic [7:0]          underrun_count,
   output logic                overrun
);

   localparam int unsigned MIC_W    = cnt_width(NUM_MICS);
   localparam int unsigned SAMPLE_W = cnt_width(SAMPLES_PER_FRAME);

   state_t                   state;
   logic [MIC_W-1:0]         mic;
   logic [SAMPLE_W-1:0]      sample;
   logic                     last;
   logic [FETCH_LATENCY-1:0] fetch;
   logic [NUM_MICS-1:0]      rdreq_q;
   logic [7:0]               tx_data_q;
   logic                     fetch_fifo;
   logic [MIC_W-1:0]         fetch_mic;
   logic [7:0]               fetch_byte;
   logic                     pending;
   logic                     accept;
   logic                     unused_sample;
   logic [BIT_WIDTH-1:0]     words [NUM_MICS];

   for (genvar g = 0; g < NUM_MICS; g++) begin : g_words
      assign words[g] = bus.fifo_q[g*BIT_WIDTH +: BIT_WIDTH];
   end

   readout_cursor #(
      .NUM_MICS         (NUM_MICS),
      .SAMPLES_PER_FRAME(SAMPLES_PER_FRAME)
   ) u_cursor (
      .clk    (clk),
      .rst    (rst),
      .clear  (bus.frame_start),
      .advance(accept && (state == DATA)),
      .mic    (mic),
      .sample (sample),
      .last   (last)
   );

   // Frame end is taken from the cursor's last flag; sample is informational.
   assign unused_sample = ^sample;

   assign pending = |fetch;
   assign accept  = bus.byte_req && !bus.frame_start && !pending;

   // A restart or reset in the strobe cycle must keep the FIFO from popping.
   assign bus.fifo_rdreq = (rst || bus.frame_start) ? '0 : rdreq_q;
   assign bus.tx_valid   = fetch[FETCH_LATENCY-1];
   assign bus.tx_data    = tx_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         fetch          <= '0;
         rdreq_q        <= '0;
         tx_data_q      <= IDLE_BYTE;
         fetch_fifo     <= 1'b0;
         fetch_mic      <= '0;
         fetch_byte     <= IDLE_BYTE;
         busy           <= 1'b0;
         frame_count    <= '0;
         underrun_count <= '0;
         overrun        <= 1'b0;
      end else begin
         fetch   <= {fetch[FETCH_LATENCY-2:0], accept};
         rdreq_q <= '0;
         if (bus.frame_start) begin
            state          <= HDR0;
            fetch          <= '0;
            busy           <= 1'b1;
            underrun_count <= '0;
            overrun        <= 1'b0;
         end else begin
            if (fetch[FETCH_LATENCY-2]) begin
               tx_data_q <= fetch_fifo ? 8'(words[fetch_mic]) : fetch_byte;
            end
            if (bus.byte_req && pending) begin
               overrun <= 1'b1;
            end
            if (accept) begin
               fetch_fifo <= 1'b0;
               fetch_mic  <= mic;
               fetch_byte <= IDLE_BYTE;
               case (state)
                  HDR0: begin
                     fetch_byte <= HDR_BYTE;
                     state      <= HDR1;
                  end
                  HDR1: begin
                     fetch_byte <= frame_count;
                     state      <= DATA;
                  end
                  DATA: begin
                     if (bus.fifo_rdempty[mic]) begin
                        fetch_byte <= FILL_BYTE;
                        if (underrun_count != 8'hFF) begin
                           underrun_count <= underrun_count + 8'd1;
                        end
                     end else begin
                        fetch_fifo <= 1'b1;
                        rdreq_q    <= NUM_MICS'(1) << mic;
                     end
                     if (last) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 8'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
